// File: rtl/core_pkg.sv
// Shared definitions for the integer register file and its scoreboard.
//   rf_state_t    : sequencer state (zero-filling or usable)
//   XLEN_DEFAULT  : default register width
//   REG_ZERO      : index of the architectural zero register
//   addr_in_range : true when an address names an existing register
package core_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_ZERO     = 0;

    // Addresses are widened to 32 bits by the caller so the compare
    // stays meaningful when NUM_REGS is not a power of two.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input int unsigned num_regs);
        return addr < num_regs;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending scoreboard for hazard detection.
//   clk, rst            : core clock, async active-high reset
//   flush_i             : clears every pending bit (zero-fill request)
//   issue_fire_i/addr_i : qualified issue, sets the destination's bit
//   wb0/wb1_fire_i/addr : qualified write-backs, clear the target's bit
//   rd_addr_i           : packed read addresses, ADDR_W bits per port
//   rd_pending_o        : pending bit per read port, with early-clear
module rf_scoreboard
    import core_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int ADDR_W   = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     issue_fire_i,
    input  logic [ADDR_W-1:0]        issue_addr_i,
    input  logic                     wb0_fire_i,
    input  logic [ADDR_W-1:0]        wb0_addr_i,
    input  logic                     wb1_fire_i,
    input  logic [ADDR_W-1:0]        wb1_addr_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD-1:0]        rd_pending_o
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // Set is applied after the clears so a same-cycle issue (the newer
    // producer) keeps the bit pending.
    always_comb begin
        pending_d = pending_q;
        if (flush_i) begin
            pending_d = '0;
        end else begin
            if (wb0_fire_i)   pending_d[wb0_addr_i]   = 1'b0;
            if (wb1_fire_i)   pending_d[wb1_addr_i]   = 1'b0;
            if (issue_fire_i) pending_d[issue_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending_q <= '0;
        else     pending_q <= pending_d;
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              in_rng;
        logic              wb_hit;
        logic              iss_hit;

        assign a       = rd_addr_i[i*ADDR_W +: ADDR_W];
        assign in_rng  = addr_in_range(32'(a), NUM_REGS);
        assign wb_hit  = (wb0_fire_i && wb0_addr_i == a) ||
                         (wb1_fire_i && wb1_addr_i == a);
        assign iss_hit = issue_fire_i && issue_addr_i == a;
        assign rd_pending_o[i] = in_rng && pending_q[a] && !(wb_hit && !iss_hit);
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file with zero-fill sequencer.
//   clk, rst          : core clock, async active-high reset
//   rd_addr/rd_data   : NUM_RD combinational read ports (packed slices)
//   rd_pending        : scoreboard pending bit of each addressed register
//   wb0_*/wb1_*       : write-back ports (wb1 wins on address collision)
//   issue_en/addr     : marks a destination as pending
//   clear_req         : request a zero-fill of every register
//   ready             : file usable; low while zero-filling
module register_file_mp
    import core_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEFAULT,
    parameter  int NUM_REGS = 32,
    parameter  int NUM_RD   = 2,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*XLEN-1:0]   rd_data,
    output logic [NUM_RD-1:0]        rd_pending,
    input  logic                     wb0_en,
    input  logic [ADDR_W-1:0]        wb0_addr,
    input  logic [XLEN-1:0]          wb0_data,
    input  logic                     wb1_en,
    input  logic [ADDR_W-1:0]        wb1_addr,
    input  logic [XLEN-1:0]          wb1_data,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic                     clear_req,
    output logic                     ready
);

    // idx carries one spare bit so a power-of-two depth never wraps
    // before the last-entry compare.
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_REGS - 1);

    rf_state_t         state_q, state_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [XLEN-1:0]   mem_q [NUM_REGS];
    logic              wb0_fire, wb1_fire, issue_fire;
    logic [NUM_RD-1:0] sb_pending;

    assign ready = (state_q == RF_READY);

    // A port "fires" only when it will actually change architectural state.
    assign wb0_fire   = ready && wb0_en && addr_in_range(32'(wb0_addr), NUM_REGS) &&
                        !(ZERO_REG != 0 && wb0_addr == ADDR_W'(REG_ZERO));
    assign wb1_fire   = ready && wb1_en && addr_in_range(32'(wb1_addr), NUM_REGS) &&
                        !(ZERO_REG != 0 && wb1_addr == ADDR_W'(REG_ZERO));
    assign issue_fire = ready && issue_en && addr_in_range(32'(issue_addr), NUM_REGS) &&
                        !(ZERO_REG != 0 && issue_addr == ADDR_W'(REG_ZERO));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            RF_CLEAR: begin
                if (idx_q == LAST_IDX) begin
                    state_d = RF_READY;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            RF_READY: begin
                if (clear_req) begin
                    state_d = RF_CLEAR;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = RF_CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Storage has no reset; the sequencer zero-fills it. wb1 is written
    // last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (state_q == RF_CLEAR) begin
            mem_q[idx_q[ADDR_W-1:0]] <= '0;
        end else begin
            if (wb0_fire) mem_q[wb0_addr] <= wb0_data;
            if (wb1_fire) mem_q[wb1_addr] <= wb1_data;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [XLEN-1:0]   val;

        assign a = rd_addr[i*ADDR_W +: ADDR_W];

        always_comb begin
            val = '0;
            if (!ready)
                val = '0;
            else if (ZERO_REG != 0 && a == ADDR_W'(REG_ZERO))
                val = '0;
            else if (BYPASS != 0 && wb1_fire && wb1_addr == a)
                val = wb1_data;
            else if (BYPASS != 0 && wb0_fire && wb0_addr == a)
                val = wb0_data;
            else if (addr_in_range(32'(a), NUM_REGS))
                val = mem_q[a];
        end

        assign rd_data[i*XLEN +: XLEN] = val;
        assign rd_pending[i]           = ready && sb_pending[i];
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (ready && clear_req),
        .issue_fire_i (issue_fire),
        .issue_addr_i (issue_addr),
        .wb0_fire_i   (wb0_fire),
        .wb0_addr_i   (wb0_addr),
        .wb1_fire_i   (wb1_fire),
        .wb1_addr_i   (wb1_addr),
        .rd_addr_i    (rd_addr),
        .rd_pending_o (sb_pending)
    );

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NRD    = 2;
    localparam int AW     = 5;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [AW-1:0]    ra0, ra1;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*XLEN-1:0] rd_data, rd_data_nb;
    logic [NRD-1:0]   rd_pending, rd_pending_nb;
    logic             wb0_en, wb1_en, issue_en, clear_req;
    logic [AW-1:0]    wb0_addr, wb1_addr, issue_addr;
    logic [XLEN-1:0]  wb0_data, wb1_data;
    logic             ready, ready_nb;

    int n_cmp  = 0;
    int n_fail = 0;
    exp_t exp_q[$];

    assign rd_addr = {ra1, ra0};

    always #5 clk = ~clk;

    register_file_mp #(.BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_pending(rd_pending), .wb0_en(wb0_en), .wb0_addr(wb0_addr),
        .wb0_data(wb0_data), .wb1_en(wb1_en), .wb1_addr(wb1_addr),
        .wb1_data(wb1_data), .issue_en(issue_en), .issue_addr(issue_addr),
        .clear_req(clear_req), .ready(ready)
    );

    register_file_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb),
        .rd_pending(rd_pending_nb), .wb0_en(wb0_en), .wb0_addr(wb0_addr),
        .wb0_data(wb0_data), .wb1_en(wb1_en), .wb1_addr(wb1_addr),
        .wb1_data(wb1_data), .issue_en(issue_en), .issue_addr(issue_addr),
        .clear_req(clear_req), .ready(ready_nb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb0_en = 0; wb1_en = 0; issue_en = 0; clear_req = 0;
    endtask

    // Counts edges until ready rises; 100 is a safety bound.
    task automatic count_to_ready(output int n);
        n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
    endtask

    int n;

    initial begin
        rst = 1; ra0 = 0; ra1 = 0;
        wb0_addr = 0; wb1_addr = 0; issue_addr = 0;
        wb0_data = 0; wb1_data = 0;
        idle_inputs();
        #3;
        push("rst_ready", 32'd0);      pop_chk({31'd0, ready});
        push("rst_rd0", 32'd0);        pop_chk(rd_data[31:0]);
        push("rst_pending", 32'd0);    pop_chk({30'd0, rd_pending});
        #9 rst = 0;

        // 1: zero-fill after reset
        ra0 = 5'd3;
        tick();
        push("clear_rd0", 32'd0);      pop_chk(rd_data[31:0]);
        n = 1;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        push("reset_fill_edges", 32'd32); pop_chk(n);
        for (int r = 1; r < NREGS; r++) begin
            ra0 = AW'(r);
            #1;
            push($sformatf("fill_x%0d", r), 32'd0);
            pop_chk(rd_data[31:0]);
        end

        // 2: bypass vs. storage
        ra0 = 5; wb0_en = 1; wb0_addr = 5; wb0_data = 32'hDEADBEEF;
        #1;
        push("byp_same", 32'hDEADBEEF);  pop_chk(rd_data[31:0]);
        push("nobyp_same", 32'h0);       pop_chk(rd_data_nb[31:0]);
        tick(); idle_inputs(); #1;
        push("byp_next", 32'hDEADBEEF);  pop_chk(rd_data[31:0]);
        push("nobyp_next", 32'hDEADBEEF); pop_chk(rd_data_nb[31:0]);

        // 3: wb1 wins; x0 hardwired
        ra0 = 7; wb0_en = 1; wb0_addr = 7; wb0_data = 32'h11;
        wb1_en = 1; wb1_addr = 7; wb1_data = 32'h22;
        #1;
        push("wb_collide_byp", 32'h22);   pop_chk(rd_data[31:0]);
        tick(); idle_inputs(); #1;
        push("wb_collide_store", 32'h22); pop_chk(rd_data[31:0]);
        push("wb_collide_nb", 32'h22);    pop_chk(rd_data_nb[31:0]);
        ra0 = 0; wb0_en = 1; wb0_addr = 0; wb0_data = 32'hFFFFFFFF;
        #1;
        push("x0_same", 32'h0);           pop_chk(rd_data[31:0]);
        tick(); idle_inputs(); #1;
        push("x0_next", 32'h0);           pop_chk(rd_data_nb[31:0]);

        // 4: scoreboard
        ra1 = 3; issue_en = 1; issue_addr = 3;
        #1;
        push("pend_before", 32'd0);       pop_chk({31'd0, rd_pending[1]});
        tick(); idle_inputs(); #1;
        push("pend_set", 32'd1);          pop_chk({31'd0, rd_pending[1]});
        wb1_en = 1; wb1_addr = 3; wb1_data = 32'h5;
        #1;
        push("pend_early_clr", 32'd0);    pop_chk({31'd0, rd_pending[1]});
        push("wb1_byp_rd1", 32'h5);       pop_chk(rd_data[63:32]);
        tick(); idle_inputs(); #1;
        push("pend_cleared", 32'd0);      pop_chk({31'd0, rd_pending[1]});
        issue_en = 1; issue_addr = 3;
        tick(); idle_inputs();
        issue_en = 1; issue_addr = 3; wb0_en = 1; wb0_addr = 3; wb0_data = 32'h9;
        #1;
        push("pend_iss_wb_same", 32'd1);  pop_chk({31'd0, rd_pending[1]});
        tick(); idle_inputs(); #1;
        push("pend_set_wins", 32'd1);     pop_chk({31'd0, rd_pending[1]});
        issue_en = 1; issue_addr = 0; ra1 = 0;
        tick(); idle_inputs(); #1;
        push("pend_x0", 32'd0);           pop_chk({31'd0, rd_pending[1]});

        // 5: clear_req zero-fill; x3 still pending going in
        ra0 = 9; ra1 = 3; wb0_en = 1; wb0_addr = 9; wb0_data = 32'h1234;
        tick(); idle_inputs(); #1;
        push("x9_written", 32'h1234);     pop_chk(rd_data[31:0]);
        clear_req = 1;
        tick(); idle_inputs();
        wb0_en = 1; wb0_addr = 9; wb0_data = 32'hFFFF;
        #1;
        push("clr_ready_low", 32'd0);     pop_chk({31'd0, ready});
        push("clr_rd0", 32'd0);           pop_chk(rd_data[31:0]);
        count_to_ready(n);
        idle_inputs();
        #1;
        push("clear_edges", 32'd32);      pop_chk(n);
        push("x9_after_clr", 32'h0);      pop_chk(rd_data[31:0]);
        push("pend_after_clr", 32'd0);    pop_chk({30'd0, rd_pending});

        // 6: reset mid-clear restarts the sequencer
        clear_req = 1;
        tick(); idle_inputs();
        for (int k = 0; k < 10; k++) tick();
        #2 rst = 1;
        #1;
        push("rst_mid_ready", 32'd0);     pop_chk({31'd0, ready});
        @(posedge clk);
        #5 rst = 0;
        count_to_ready(n);
        push("rst_mid_edges", 32'd32);    pop_chk(n);

        if (exp_q.size() != 0) chk("scoreboard_leftover", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule
